// File: rtl/isp8_pc_stack.sv
// isp8 program counter and call/return stack: selects the next PROM fetch address from
// decoded branch/call/return strobes and saves/restores Z/C across interrupts.
module isp8_pc_stack #(
  parameter int unsigned       PROM_AW     = 10,
  parameter int unsigned       STACK_DEPTH = 16,
  parameter logic [PROM_AW-1:0] INT_VECTOR = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  input  logic               bz,
  input  logic               bnz,
  input  logic               bc,
  input  logic               bnc,
  input  logic               b,
  input  logic               callz,
  input  logic               callnz,
  input  logic               callc,
  input  logic               callnc,
  input  logic               call,
  input  logic               ret,
  input  logic               iret,
  input  logic [PROM_AW-1:0] addr_jmp,
  input  logic               flag_z,
  input  logic               flag_c,
  input  logic               intr_req,
  output logic [PROM_AW-1:0] prom_addr,
  output logic               flag_rst_v,
  output logic               flag_rst_z,
  output logic               flag_rst_c,
  output logic               stack_ovf,
  output logic               stack_unf
);

  localparam int unsigned SpW  = $clog2(STACK_DEPTH);
  localparam int unsigned CntW = $clog2(STACK_DEPTH + 1);
  localparam int unsigned EntW = PROM_AW + 2;

  // Entry layout: {z, c, return address}
  logic [EntW-1:0]    stack_mem [STACK_DEPTH];

  logic [PROM_AW-1:0] pc_q, pc_d;
  logic [SpW-1:0]     sp_q, sp_d, sp_top;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               rst_v_q, rst_v_d;
  logic               rst_z_q, rst_z_d;
  logic               rst_c_q, rst_c_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;

  logic [PROM_AW-1:0] seq_addr;
  logic [PROM_AW-1:0] tgt_addr;
  logic [EntW-1:0]    top_entry;
  logic               br_taken;
  logic               call_taken;
  logic               push;
  logic               pop;

  assign seq_addr  = pc_q + PROM_AW'(1);
  assign tgt_addr  = pc_q + addr_jmp;
  assign sp_top    = sp_q - SpW'(1);
  assign top_entry = stack_mem[sp_top];

  assign br_taken   = b | (bz & flag_z) | (bnz & ~flag_z) | (bc & flag_c) | (bnc & ~flag_c);
  assign call_taken = call | (callz & flag_z) | (callnz & ~flag_z) |
                      (callc & flag_c) | (callnc & ~flag_c);

  always_comb begin
    pc_d    = pc_q;
    sp_d    = sp_q;
    cnt_d   = cnt_q;
    rst_v_d = 1'b0;
    rst_z_d = rst_z_q;
    rst_c_d = rst_c_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push    = 1'b0;
    pop     = 1'b0;

    if (ce) begin
      pc_d = seq_addr;
      if (intr_req) begin
        push = 1'b1;
        pc_d = INT_VECTOR;
      end else if (ret || iret) begin
        pop  = 1'b1;
        pc_d = top_entry[PROM_AW-1:0];
        if (iret) begin
          rst_v_d = 1'b1;
          rst_z_d = top_entry[PROM_AW+1];
          rst_c_d = top_entry[PROM_AW];
        end
      end else if (call_taken) begin
        push = 1'b1;
        pc_d = tgt_addr;
      end else if (br_taken) begin
        pc_d = tgt_addr;
      end

      // Full push overwrites the oldest slot; empty pop still moves sp.
      if (push) begin
        sp_d = sp_q + SpW'(1);
        if (cnt_q == CntW'(STACK_DEPTH)) ovf_d = 1'b1;
        else                             cnt_d = cnt_q + CntW'(1);
      end
      if (pop) begin
        sp_d = sp_top;
        if (cnt_q == '0) unf_d = 1'b1;
        else             cnt_d = cnt_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= '0;
      sp_q    <= '0;
      cnt_q   <= '0;
      rst_v_q <= 1'b0;
      rst_z_q <= 1'b0;
      rst_c_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      cnt_q   <= cnt_d;
      rst_v_q <= rst_v_d;
      rst_z_q <= rst_z_d;
      rst_c_q <= rst_c_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) stack_mem[sp_q] <= {flag_z, flag_c, seq_addr};
  end

  assign prom_addr  = pc_q;
  assign flag_rst_v = rst_v_q;
  assign flag_rst_z = rst_z_q;
  assign flag_rst_c = rst_c_q;
  assign stack_ovf  = ovf_q;
  assign stack_unf  = unf_q;

endmodule

// File: tb/tb_isp8_pc_stack.sv
// Scoreboard bench for isp8_pc_stack: a behavioural PC/stack model queues the expected
// state for each driven cycle and each scenario task pops and compares after the edge.
module tb_isp8_pc_stack;

  localparam logic [11:0] SBz    = 12'b1000_0000_0000;
  localparam logic [11:0] SBnz   = 12'b0100_0000_0000;
  localparam logic [11:0] SBc    = 12'b0010_0000_0000;
  localparam logic [11:0] SBnc   = 12'b0001_0000_0000;
  localparam logic [11:0] SB     = 12'b0000_1000_0000;
  localparam logic [11:0] SCallz = 12'b0000_0100_0000;
  localparam logic [11:0] SCall  = 12'b0000_0000_0100;
  localparam logic [11:0] SRet   = 12'b0000_0000_0010;
  localparam logic [11:0] SIret  = 12'b0000_0000_0001;
  localparam logic [11:0] SNone  = 12'b0;
  localparam logic [9:0]  IntVec = 10'h000;

  logic clk = 1'b0;
  logic rst, ce, bz, bnz, bc, bnc, b, callz, callnz, callc, callnc, call, ret, iret;
  logic [9:0] addr_jmp;
  logic flag_z, flag_c, intr_req;
  logic [9:0] prom_addr;
  logic flag_rst_v, flag_rst_z, flag_rst_c, stack_ovf, stack_unf;

  always #5 clk = ~clk;

  isp8_pc_stack #(.PROM_AW(10), .STACK_DEPTH(16), .INT_VECTOR(IntVec)) dut (
    .clk(clk), .rst(rst), .ce(ce),
    .bz(bz), .bnz(bnz), .bc(bc), .bnc(bnc), .b(b),
    .callz(callz), .callnz(callnz), .callc(callc), .callnc(callnc), .call(call),
    .ret(ret), .iret(iret), .addr_jmp(addr_jmp), .flag_z(flag_z), .flag_c(flag_c),
    .intr_req(intr_req), .prom_addr(prom_addr), .flag_rst_v(flag_rst_v),
    .flag_rst_z(flag_rst_z), .flag_rst_c(flag_rst_c), .stack_ovf(stack_ovf),
    .stack_unf(stack_unf)
  );

  typedef struct packed {
    logic [9:0] pc;
    logic [4:0] fl;  // {v, z, c, ovf, unf}
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int n_chk = 0;
  int n_fail = 0;

  logic [9:0]  m_pc;
  logic [11:0] m_stk [16];
  logic [3:0]  m_sp;
  int          m_cnt;
  logic        m_v, m_z, m_c, m_ovf, m_unf;

  // Applies one cycle of stimulus, advances the model, queues the expected state.
  task automatic drive(input logic i_rst, input logic i_ce, input logic [11:0] s,
                       input logic [9:0] jmp, input logic z, input logic c, input logic intr);
    logic [9:0]  seq, tgt;
    logic [11:0] ent;
    logic        brt, clt;
    @(negedge clk);
    rst = i_rst; ce = i_ce; addr_jmp = jmp; flag_z = z; flag_c = c; intr_req = intr;
    {bz, bnz, bc, bnc, b, callz, callnz, callc, callnc, call, ret, iret} = s;
    if (i_rst) begin
      m_pc = '0; m_sp = '0; m_cnt = 0;
      m_v = 0; m_z = 0; m_c = 0; m_ovf = 0; m_unf = 0;
    end else begin
      m_v = 1'b0;
      if (i_ce) begin
        seq = m_pc + 10'd1;
        tgt = m_pc + jmp;
        brt = s[7] | (s[11] & z) | (s[10] & ~z) | (s[9] & c) | (s[8] & ~c);
        clt = s[2] | (s[6] & z) | (s[5] & ~z) | (s[4] & c) | (s[3] & ~c);
        if (intr || (!(s[1] | s[0]) && clt)) begin
          m_stk[m_sp] = {z, c, seq};
          m_sp = m_sp + 4'd1;
          if (m_cnt == 16) m_ovf = 1'b1; else m_cnt++;
          m_pc = intr ? IntVec : tgt;
        end else if (s[1] | s[0]) begin
          m_sp = m_sp - 4'd1;
          ent = m_stk[m_sp];
          if (m_cnt == 0) m_unf = 1'b1; else m_cnt--;
          m_pc = ent[9:0];
          if (s[0]) begin
            m_v = 1'b1; m_z = ent[11]; m_c = ent[10];
          end
        end else if (brt) begin
          m_pc = tgt;
        end else begin
          m_pc = seq;
        end
      end
    end
    sb.push_back('{pc: m_pc, fl: {m_v, m_z, m_c, m_ovf, m_unf}});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, SCall, 10'h055, 1'b1, 1'b1, 1'b1);
    e = sb.pop_front();
    n_chk++;
    if (prom_addr !== 10'h000 || prom_addr !== e.pc) begin
      n_fail++; $display("FAIL reset_pc: got %h want %h", prom_addr, e.pc);
    end
    n_chk++;
    if ({flag_rst_v, flag_rst_z, flag_rst_c, stack_ovf, stack_unf} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 00000",
               {flag_rst_v, flag_rst_z, flag_rst_c, stack_ovf, stack_unf});
    end
  endtask

  task automatic test_sequential();
    drive(1'b1, 1'b0, SNone, 10'h0, 1'b0, 1'b0, 1'b0);
    void'(sb.pop_front());
    for (int i = 0; i < 7; i++) begin
      // Cycle 3 holds ce low and presents a branch that must be ignored.
      if (i == 3) drive(1'b0, 1'b0, SB, 10'h100, 1'b0, 1'b0, 1'b0);
      else        drive(1'b0, 1'b1, SNone, 10'h0, 1'b0, 1'b0, 1'b0);
      e = sb.pop_front();
      n_chk++;
      if (prom_addr !== e.pc) begin
        n_fail++; $display("FAIL seq_pc[%0d]: got %h want %h", i, prom_addr, e.pc);
      end
      n_chk++;
      if ({flag_rst_v, flag_rst_z, flag_rst_c, stack_ovf, stack_unf} !== e.fl) begin
        n_fail++; $display("FAIL seq_flags[%0d]: got %b want %b", i,
                           {flag_rst_v, flag_rst_z, flag_rst_c, stack_ovf, stack_unf}, e.fl);
      end
    end
    n_chk++;
    if (prom_addr !== 10'h006) begin
      n_fail++; $display("FAIL seq_final: got %h want 006", prom_addr);
    end
  endtask

  task automatic test_branch();
    logic [11:0] s_tab [6] = '{SB, SBz, SB, SBz, SBnc, SBc};
    logic [9:0]  j_tab [6] = '{10'h010, 10'h3FE, 10'h000, 10'h3FE, 10'h004, 10'h100};
    logic        z_tab [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [9:0]  p_tab [6] = '{10'h010, 10'h00E, 10'h00E, 10'h00F, 10'h013, 10'h014};
    drive(1'b1, 1'b0, SNone, 10'h0, 1'b0, 1'b0, 1'b0);
    void'(sb.pop_front());
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, s_tab[i], j_tab[i], z_tab[i], 1'b0, 1'b0);
      e = sb.pop_front();
      n_chk++;
      if (prom_addr !== e.pc || prom_addr !== p_tab[i]) begin
        n_fail++;
        $display("FAIL branch[%0d]: got %h want %h", i, prom_addr, p_tab[i]);
      end
    end
  endtask

  task automatic test_call_ret();
    logic [11:0] s_tab [5] = '{SB, SCall, SCallz, SRet, SRet};
    logic [9:0]  j_tab [5] = '{10'h020, 10'h010, 10'h050, 10'h000, 10'h000};
    logic [9:0]  p_tab [5] = '{10'h020, 10'h030, 10'h031, 10'h021, 10'h000};
    drive(1'b1, 1'b0, SNone, 10'h0, 1'b0, 1'b0, 1'b0);
    void'(sb.pop_front());
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, s_tab[i], j_tab[i], 1'b0, 1'b0, 1'b0);
      e = sb.pop_front();
      n_chk++;
      if (prom_addr !== e.pc || prom_addr !== p_tab[i]) begin
        n_fail++; $display("FAIL call_ret[%0d]: got %h want %h", i, prom_addr, p_tab[i]);
      end
    end
    n_chk++;
    if (stack_unf !== 1'b0 || stack_ovf !== 1'b0) begin
      n_fail++; $display("FAIL call_ret_flags: ovf=%b unf=%b want 0 0", stack_ovf, stack_unf);
    end
    // A second ret must underflow, proving the first ret brought count back to zero.
    drive(1'b0, 1'b1, SRet, 10'h0, 1'b0, 1'b0, 1'b0);
    void'(sb.pop_front());
    n_chk++;
    if (stack_unf !== 1'b1) begin
      n_fail++; $display("FAIL call_ret_count: unf=%b want 1", stack_unf);
    end
  endtask

  task automatic test_intr_iret();
    drive(1'b1, 1'b0, SNone, 10'h0, 1'b0, 1'b0, 1'b0);
    void'(sb.pop_front());
    drive(1'b0, 1'b1, SB, 10'h040, 1'b0, 1'b0, 1'b0);
    void'(sb.pop_front());
    drive(1'b0, 1'b1, SBnz, 10'h010, 1'b1, 1'b0, 1'b1);
    e = sb.pop_front();
    n_chk++;
    if (prom_addr !== e.pc || prom_addr !== IntVec) begin
      n_fail++; $display("FAIL intr_pc: got %h want %h", prom_addr, IntVec);
    end
    drive(1'b0, 1'b1, SIret, 10'h0, 1'b0, 1'b1, 1'b0);
    e = sb.pop_front();
    n_chk++;
    if (prom_addr !== 10'h041 || prom_addr !== e.pc) begin
      n_fail++; $display("FAIL iret_pc: got %h want 041", prom_addr);
    end
    n_chk++;
    if ({flag_rst_v, flag_rst_z, flag_rst_c} !== 3'b110 || {flag_rst_v, flag_rst_z,
        flag_rst_c, stack_ovf, stack_unf} !== e.fl) begin
      n_fail++; $display("FAIL iret_flags: got v/z/c %b want 110",
                         {flag_rst_v, flag_rst_z, flag_rst_c});
    end
    drive(1'b0, 1'b0, SNone, 10'h0, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front();
    n_chk++;
    if ({flag_rst_v, flag_rst_z, flag_rst_c} !== 3'b010 || prom_addr !== e.pc) begin
      n_fail++; $display("FAIL iret_pulse: got v/z/c %b pc %h want 010 pc %h",
                         {flag_rst_v, flag_rst_z, flag_rst_c}, prom_addr, e.pc);
    end
  endtask

  task automatic test_overflow();
    drive(1'b1, 1'b0, SNone, 10'h0, 1'b0, 1'b0, 1'b0);
    void'(sb.pop_front());
    for (int i = 1; i <= 17; i++) begin
      drive(1'b0, 1'b1, SCall, 10'h001, i[0], 1'b0, 1'b0);
      e = sb.pop_front();
      n_chk++;
      if (prom_addr !== e.pc || stack_ovf !== (i == 17)) begin
        n_fail++; $display("FAIL ovf_call[%0d]: pc %h ovf %b want pc %h ovf %b",
                           i, prom_addr, stack_ovf, e.pc, (i == 17));
      end
    end
    // Returns pop 17, 16, ... 2: slot 0 was overwritten by the 17th call.
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b1, SRet, 10'h0, 1'b0, 1'b0, 1'b0);
      e = sb.pop_front();
      n_chk++;
      if (prom_addr !== e.pc || prom_addr !== 10'(17 - i) || stack_unf !== 1'b0) begin
        n_fail++; $display("FAIL ovf_ret[%0d]: pc %h unf %b want pc %h unf 0",
                           i, prom_addr, stack_unf, 10'(17 - i));
      end
    end
    drive(1'b0, 1'b1, SRet, 10'h0, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front();
    n_chk++;
    if (stack_unf !== 1'b1 || stack_ovf !== 1'b1) begin
      n_fail++; $display("FAIL unf_sticky: ovf %b unf %b want 1 1", stack_ovf, stack_unf);
    end
  endtask

  task automatic test_wrap_reset();
    drive(1'b1, 1'b0, SNone, 10'h0, 1'b0, 1'b0, 1'b0);
    void'(sb.pop_front());
    drive(1'b0, 1'b1, SB, 10'h3FF, 1'b0, 1'b0, 1'b0);
    void'(sb.pop_front());
    drive(1'b0, 1'b1, SNone, 10'h0, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front();
    n_chk++;
    if (prom_addr !== 10'h000 || prom_addr !== e.pc) begin
      n_fail++; $display("FAIL pc_wrap: got %h want 000", prom_addr);
    end
    for (int i = 0; i < 17; i++) begin
      drive(1'b0, 1'b1, SCall, 10'h002, 1'b0, 1'b0, 1'b0);
      void'(sb.pop_front());
    end
    drive(1'b1, 1'b1, SCall, 10'h002, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front();
    n_chk++;
    if (prom_addr !== 10'h000 || {flag_rst_v, flag_rst_z, flag_rst_c, stack_ovf,
        stack_unf} !== e.fl) begin
      n_fail++; $display("FAIL mid_reset: pc %h ovf %b want pc 000 ovf 0", prom_addr, stack_ovf);
    end
    drive(1'b0, 1'b1, SRet, 10'h0, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front();
    n_chk++;
    if (stack_unf !== 1'b1 || stack_ovf !== 1'b0) begin
      n_fail++; $display("FAIL reset_count: unf %b ovf %b want 1 0", stack_unf, stack_ovf);
    end
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0; addr_jmp = '0; flag_z = 1'b0; flag_c = 1'b0; intr_req = 1'b0;
    {bz, bnz, bc, bnc, b, callz, callnz, callc, callnc, call, ret, iret} = '0;
    test_reset();
    test_sequential();
    test_branch();
    test_call_ret();
    test_intr_iret();
    test_overflow();
    test_wrap_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
